// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one DRAM port between IF and LSU, one transaction in flight,
//            routes responses back and forces an error response on timeout.
//            Define MEM_ARB_RR_EN for round-robin ties (default: LSU priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              if_req_ip,
    input  logic [ADDR_W-1:0] if_addr_ip,
    output logic              if_gnt_op,
    output logic              if_rvalid_op,
    output logic [DATA_W-1:0] if_rdata_op,
    input  logic              lsu_req_ip,
    input  logic              lsu_we_ip,
    input  logic [3:0]        lsu_be_ip,
    input  logic [ADDR_W-1:0] lsu_addr_ip,
    input  logic [DATA_W-1:0] lsu_wdata_ip,
    output logic              lsu_gnt_op,
    output logic              lsu_rvalid_op,
    output logic [DATA_W-1:0] lsu_rdata_op,
    input  logic              mem_gnt_ip,
    output logic              mem_req_op,
    output logic              mem_we_op,
    output logic [3:0]        mem_be_op,
    output logic [ADDR_W-1:0] mem_addr_op,
    output logic [DATA_W-1:0] mem_wdata_op,
    input  logic              mem_rvalid_ip,
    input  logic [DATA_W-1:0] mem_rdata_ip,
    output logic              busy_op,
    output logic              err_op
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic            OWN_LSU  = 1'b0;
    localparam logic            OWN_IF   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              store_q, store_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              grant;
    logic              winner;
    logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q, last_owner_d;
    logic last_owner;
    // The retiring owner in RESP is already the most recent one for a same-cycle tie.
    assign last_owner = (state_q == ST_RESP) ? owner_q : last_owner_q;
`endif

    always_comb begin
        if (if_req_ip && lsu_req_ip) begin
`ifdef MEM_ARB_RR_EN
            winner = (last_owner == OWN_IF) ? OWN_LSU : OWN_IF;
`else
            winner = OWN_LSU;
`endif
        end else begin
            winner = if_req_ip ? OWN_IF : OWN_LSU;
        end
    end

    assign grant = mem_en && mem_gnt_ip && (if_req_ip || lsu_req_ip)
                   && (state_q != ST_WAIT) && !reset;

    // Stores return no data; a timed-out transaction returns zero.
    assign resp_data = (mem_rvalid_ip && !store_q) ? mem_rdata_ip : '0;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        store_d     = store_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        if_gnt_op    = 1'b0;
        lsu_gnt_op   = 1'b0;
        mem_req_op   = 1'b0;
        mem_we_op    = 1'b0;
        mem_be_op    = 4'h0;
        mem_addr_op  = '0;
        mem_wdata_op = '0;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid_ip || (cnt_q == CNT_LAST)) begin
                    state_d = ST_RESP;
                    err_d   = !mem_rvalid_ip;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = resp_data;
                    end else begin
                        lsu_rdata_d = resp_data;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef MEM_ARB_RR_EN
                last_owner_d = owner_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            state_d    = ST_WAIT;
            owner_d    = winner;
            store_d    = (winner == OWN_LSU) && lsu_we_ip;
            err_d      = 1'b0;
            cnt_d      = '0;
            mem_req_op = 1'b1;
            if (winner == OWN_IF) begin
                if_gnt_op   = 1'b1;
                mem_be_op   = 4'hF;
                mem_addr_op = if_addr_ip;
            end else begin
                lsu_gnt_op   = 1'b1;
                mem_we_op    = lsu_we_ip;
                mem_be_op    = lsu_be_ip;
                mem_addr_op  = lsu_addr_ip;
                mem_wdata_op = lsu_wdata_ip;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_LSU;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_LSU;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign if_rvalid_op  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign lsu_rvalid_op = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign if_rdata_op   = if_rdata_q;
    assign lsu_rdata_op  = lsu_rdata_q;
    assign busy_op       = (state_q == ST_WAIT);
    assign err_op        = (state_q == ST_RESP) && err_q;

endmodule
`default_nettype wire
